bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock, with valid/ready handshakes on both sides. It replaces the fixed 12-bit/4-digit converter in the display and telemetry path. New capabilities: arbitrary input width and digit count, optional signed (two's-complement) input, overflow saturation, output back-pressure, and back-to-back conversions.

## Interface
- BIN_W, 12: input width in bits; range 2..32.
- DIGITS, 4: number of BCD output digits; range 1..10.
- SIGNED, 0: 1 = in_data is two's complement and the magnitude is converted; 0 = unsigned.
- clk_50m  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  converter accepts a word this cycle.
- in_data  in  BIN_W  binary operand.
- out_valid  out  1  result is valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_bcd  out  4*DIGITS  result, with the most significant digit at the top.
- out_neg  out  1  result is negative (SIGNED=1 only; otherwise 0).
- out_ovf  out  1  magnitude ≥ 10^DIGITS; out_bcd is saturated.

## Operation
- States: IDLE, CONV, DONE. Encoding comes from the package.
- Reset values: state IDLE, in_ready 1, out_valid 0, out_bcd 0, out_neg 0, out_ovf 0; internal shift, count and sticky registers 0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from state and out_ready.
- Accept occurs when in_valid & in_ready:
  - Load the magnitude register: if SIGNED and in_data[BIN_W-1], load -in_data as unsigned BIN_W bits, so the most negative value maps to 2^(BIN_W-1); otherwise load in_data.
  - Latch the sign: neg = SIGNED & in_data[BIN_W-1] & (in_data != 0).
  - Clear the BCD accumulator and the overflow sticky bit; set count = BIN_W; go to CONV.
- CONV, once per cycle:
  - Add 3 to every accumulator digit ≥ 5.
  - Shift {accumulator, magnitude} left by one.
  - If the bit shifted out of the accumulator top is 1, set the overflow sticky bit.
  - Decrement count. When count reaches 1 on this edge (the last shift), go to DONE.
- DONE:
  - out_valid = 1.
  - out_bcd = the accumulator, or all digits 4'h9 if the overflow sticky bit is set.
  - out_neg and out_ovf are the latched values.
  - Outputs are registered and stable while out_valid & !out_ready.
- On out_valid & out_ready: if in_valid is also high, accept the new word on the same edge and go directly to CONV (back-to-back). Otherwise go to IDLE and drop out_valid.
- in_data is sampled only at accept and may change afterwards.
- out_bcd, out_neg and out_ovf are don't-care while out_valid = 0, but hold their last values (no glitching to 0).
- Reset mid-operation: asynchronous return to the reset values; any conversion in progress is lost and no out_valid is emitted.
- An invalid state decodes to IDLE.
- Elaboration-time check: DIGITS ≥ 1 and BIN_W ≥ 2. Undersized DIGITS is legal, because overflow is handled.

## Timing
- Latency: the accept edge is edge 0; out_valid rises after edge BIN_W (12 cycles at default).
- Throughput: one result per BIN_W+1 cycles when back-to-back with out_ready held high. With an IDLE gap, one result per BIN_W+2 cycles.
- Zero combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready.
- Per-cycle logic depth: one add-3 per digit plus a mux. This must close at 50 MHz for BIN_W=32, DIGITS=10.

## Structure
- Package bcd_pkg holds:
  - the state typedef/localparams (IDLE, CONV, DONE);
  - localparam BCD_NINE = 4'h9;
  - function bcd_digits_needed(width), returning ceil(width·log10 2), for instantiators.
- Sub-module bcd_digit_adj: combinational, 4-bit in/4-bit out, adds 3 when the input is ≥ 5. It is instantiated DIGITS times via generate.
- The top level contains the FSM, magnitude/accumulator shift registers, counter (width $clog2(BIN_W+1)) and output registers.

## Test plan
- Unsigned, default parameters:
  - in_data=12'd4095 → out_bcd=16'h4095, out_ovf=0, out_neg=0; out_valid exactly 12 cycles after accept.
  - in_data=0 → out_bcd=16'h0000.
- SIGNED=1, BIN_W=12:
  - in_data=12'h800 (-2048) → out_bcd=16'h2048, out_neg=1.
  - in_data=12'hFFF → 16'h0001, out_neg=1.
  - in_data=12'h7FF → 16'h2047, out_neg=0.
- Overflow, BIN_W=12, DIGITS=3:
  - in_data=999 → 12'h999, out_ovf=0.
  - in_data=1000 → 12'h999, out_ovf=1.
  - in_data=4095 → out_ovf=1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → out_bcd stable, in_ready=0, and a pending in_valid is not accepted. Release with in_valid high → the next result is accepted on the same edge and arrives BIN_W cycles later.
- Back-to-back stream: 1000 random words with in_valid and out_ready held high, checked against a reference model → spacing of exactly BIN_W+1 cycles.
- Reset mid-operation: assert rst_n=0 six cycles into a conversion → outputs return to reset values immediately, with no out_valid. A new request after release converts correctly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   bcd_state_t / ST_*   : FSM encoding used by bin2bcd_seq
//   BCD_NINE             : digit value used when the result saturates
//   bcd_digits_needed()  : digits required to show any unsigned value of a given width
package bcd_pkg;

  typedef logic [1:0] bcd_state_t;

  localparam bcd_state_t ST_IDLE = 2'd0;
  localparam bcd_state_t ST_CONV = 2'd1;
  localparam bcd_state_t ST_DONE = 2'd2;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // ceil(width * log10(2)), using log10(2) ~= 0.30103 in fixed point
  function automatic int bcd_digits_needed(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// that the following left shift carries correctly into the next digit.
//   digit_in  : current accumulator digit
//   digit_out : corrected digit, ready to be shifted
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes on both sides and overflow saturation.
//   clk_50m, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data: operand handshake (in_data sampled at accept only)
//   out_valid/out_ready      : result handshake, result held until accepted
//   out_bcd                  : DIGITS BCD digits, most significant at the top
//   out_neg                  : negative operand (SIGNED=1 only)
//   out_ovf                  : magnitude did not fit, out_bcd saturated to all nines
//
// state   | meaning
// IDLE    | waiting for an operand
// CONV    | shifting one magnitude bit per cycle into the accumulator
// DONE    | result presented, waiting for out_ready
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4,
  parameter int SIGNED = 0
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  generate
    if (DIGITS < 1 || BIN_W < 2) begin : g_param_chk
      $error("bin2bcd_seq: DIGITS must be >= 1 and BIN_W >= 2");
    end
  endgenerate

  bcd_state_t         state, state_dec;
  logic [BIN_W-1:0]   mag;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_sticky;
  logic               neg;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_sh;
  logic [BIN_W-1:0]   mag_sh;
  logic               sticky_nxt;
  logic [BIN_W-1:0]   mag_load;
  logic               neg_load;
  logic               accept;

  // Unused encodings behave exactly like IDLE.
  always_comb begin
    state_dec = state;
    if (state != ST_CONV && state != ST_DONE) state_dec = ST_IDLE;
  end

  assign in_ready  = (state_dec == ST_IDLE) | ((state_dec == ST_DONE) & out_ready);
  assign out_valid = (state_dec == ST_DONE);
  assign accept    = in_valid & in_ready;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (acc[4*d +: 4]),
      .digit_out (acc_adj[4*d +: 4])
    );
  end

  assign acc_sh     = {acc_adj[ACC_W-2:0], mag[BIN_W-1]};
  assign mag_sh     = {mag[BIN_W-2:0], 1'b0};
  // A 1 leaving the top digit means the value no longer fits in DIGITS digits.
  assign sticky_nxt = ovf_sticky | acc_adj[ACC_W-1];

  // Two's-complement negate; the most negative value maps to 2^(BIN_W-1).
  assign mag_load = ((SIGNED != 0) && in_data[BIN_W-1]) ? (~in_data) + BIN_W'(1) : in_data;
  assign neg_load = (SIGNED != 0) && in_data[BIN_W-1] && (in_data != '0);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mag        <= '0;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      neg        <= 1'b0;
      out_bcd    <= '0;
      out_neg    <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (accept) begin
      mag        <= mag_load;
      neg        <= neg_load;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      cnt        <= CNT_W'(BIN_W);
      state      <= ST_CONV;
    end else begin
      case (state_dec)
        ST_CONV: begin
          acc        <= acc_sh;
          mag        <= mag_sh;
          ovf_sticky <= sticky_nxt;
          cnt        <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= ST_DONE;
            out_bcd <= sticky_nxt ? {DIGITS{BCD_NINE}} : acc_sh;
            out_neg <= neg;
            out_ovf <= sticky_nxt;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;

  // index 0: unsigned 12b/4 digits, 1: signed 12b/4 digits, 2: unsigned 12b/3 digits
  logic [2:0]        in_valid;
  logic [2:0]        in_ready;
  logic [2:0][11:0]  in_data;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [2:0]        out_neg;
  logic [2:0]        out_ovf;
  logic [15:0]       bcd_u, bcd_s;
  logic [11:0]       bcd_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk_50m = ~clk_50m;

  bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_dut_u (
    .clk_50m(clk_50m), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_bcd(bcd_u),
    .out_neg(out_neg[0]), .out_ovf(out_ovf[0]));

  bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) u_dut_s (
    .clk_50m(clk_50m), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_bcd(bcd_s),
    .out_neg(out_neg[1]), .out_ovf(out_ovf[1]));

  bin2bcd_seq #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) u_dut_o (
    .clk_50m(clk_50m), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_bcd(bcd_o),
    .out_neg(out_neg[2]), .out_ovf(out_ovf[2]));

  function automatic logic [15:0] bcd_of(input int idx);
    case (idx)
      0:       return bcd_u;
      1:       return bcd_s;
      default: return {4'h0, bcd_o};
    endcase
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_result(input int idx, output int n);
    n = 0;
    while (!out_valid[idx] && n < 100) begin
      @(posedge clk_50m);
      #1;
      n++;
    end
  endtask

  task automatic do_conv(input int idx, input logic [11:0] d, input logic [15:0] exp_bcd,
                         input logic exp_neg, input logic exp_ovf, input string tag);
    int n;
    @(negedge clk_50m);
    check_val({tag, "_in_ready"}, 32'(in_ready[idx]), 32'd1);
    in_valid[idx]  = 1'b1;
    in_data[idx]   = d;
    out_ready[idx] = 1'b1;
    @(posedge clk_50m);
    #1;
    in_valid[idx] = 1'b0;
    in_data[idx]  = 12'hA5C;
    wait_result(idx, n);
    check_val({tag, "_latency"}, 32'(n), 32'd12);
    check_val({tag, "_bcd"}, 32'(bcd_of(idx)), 32'(exp_bcd));
    check_val({tag, "_neg"}, 32'(out_neg[idx]), 32'(exp_neg));
    check_val({tag, "_ovf"}, 32'(out_ovf[idx]), 32'(exp_ovf));
    @(posedge clk_50m);
    #1;
    check_val({tag, "_released"}, 32'(out_valid[idx]), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, cyc, acc_n, got_n, last_t;
    logic        acc_now;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;
    repeat (3) @(posedge clk_50m);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("rst_in_ready%0d", i), 32'(in_ready[i]), 32'd1);
      check_val($sformatf("rst_out_valid%0d", i), 32'(out_valid[i]), 32'd0);
      check_val($sformatf("rst_bcd%0d", i), 32'(bcd_of(i)), 32'd0);
    end
    @(negedge clk_50m);
    rst_n = 1'b1;

    do_conv(0, 12'd4095, 16'h4095, 1'b0, 1'b0, "u_4095");
    do_conv(0, 12'd0,    16'h0000, 1'b0, 1'b0, "u_0");
    do_conv(0, 12'd1234, 16'h1234, 1'b0, 1'b0, "u_1234");
    do_conv(0, 12'd9,    16'h0009, 1'b0, 1'b0, "u_9");

    do_conv(1, 12'h800, 16'h2048, 1'b1, 1'b0, "s_m2048");
    do_conv(1, 12'hFFF, 16'h0001, 1'b1, 1'b0, "s_m1");
    do_conv(1, 12'h7FF, 16'h2047, 1'b0, 1'b0, "s_2047");
    do_conv(1, 12'h000, 16'h0000, 1'b0, 1'b0, "s_0");
    do_conv(1, 12'hF9C, 16'h0100, 1'b1, 1'b0, "s_m100");

    do_conv(2, 12'd999,  16'h0999, 1'b0, 1'b0, "o_999");
    do_conv(2, 12'd1000, 16'h0999, 1'b0, 1'b1, "o_1000");
    do_conv(2, 12'd4095, 16'h0999, 1'b0, 1'b1, "o_4095");
    do_conv(2, 12'd123,  16'h0123, 1'b0, 1'b0, "o_123");

    // back-pressure with a pending operand
    @(negedge clk_50m);
    in_valid[0]  = 1'b1;
    in_data[0]   = 12'd321;
    out_ready[0] = 1'b0;
    @(posedge clk_50m);
    #1;
    in_data[0] = 12'd77;
    wait_result(0, n);
    check_val("bp_latency", 32'(n), 32'd12);
    check_val("bp_bcd", 32'(bcd_u), 32'h0321);
    repeat (10) begin
      @(posedge clk_50m);
      #1;
      check_val("bp_hold_bcd", 32'(bcd_u), 32'h0321);
      check_val("bp_hold_in_ready", 32'(in_ready[0]), 32'd0);
      check_val("bp_hold_valid", 32'(out_valid[0]), 32'd1);
    end
    @(negedge clk_50m);
    out_ready[0] = 1'b1;
    #1;
    check_val("bp_release_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk_50m);
    #1;
    check_val("bp_b2b_valid_drop", 32'(out_valid[0]), 32'd0);
    in_valid[0] = 1'b0;
    wait_result(0, n);
    check_val("bp_b2b_latency", 32'(n), 32'd12);
    check_val("bp_b2b_bcd", 32'(bcd_u), 32'h0077);
    @(posedge clk_50m);

    // reset in the middle of a conversion
    @(negedge clk_50m);
    in_valid[0] = 1'b1;
    in_data[0]  = 12'd4095;
    @(posedge clk_50m);
    #1;
    in_valid[0] = 1'b0;
    repeat (6) @(posedge clk_50m);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(out_valid[0]), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    check_val("mid_rst_bcd", 32'(bcd_u), 32'd0);
    check_val("mid_rst_neg", 32'(out_neg[0]), 32'd0);
    check_val("mid_rst_ovf", 32'(out_ovf[0]), 32'd0);
    repeat (3) begin
      @(posedge clk_50m);
      #1;
      check_val("mid_rst_no_valid", 32'(out_valid[0]), 32'd0);
    end
    @(negedge clk_50m);
    rst_n = 1'b1;
    do_conv(0, 12'd2500, 16'h2500, 1'b0, 1'b0, "after_rst");

    // back-to-back stream against the reference model
    acc_n  = 0;
    got_n  = 0;
    cyc    = 0;
    last_t = -1;
    out_ready[0] = 1'b1;
    while (got_n < 1000 && cyc < 14000) begin
      @(negedge clk_50m);
      if (acc_n < 1000) begin
        in_valid[0] = 1'b1;
        in_data[0]  = 12'($urandom_range(0, 4095));
      end else begin
        in_valid[0] = 1'b0;
      end
      acc_now = in_valid[0] & in_ready[0];
      @(posedge clk_50m);
      if (acc_now) begin
        exp_q.push_back(ref_bcd(int'(in_data[0])));
        acc_n++;
      end
      #1;
      cyc++;
      if (out_valid[0]) begin
        if (exp_q.size() == 0) begin
          check_val("stream_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("stream_bcd", 32'(bcd_u), 32'(e));
        end
        if (last_t >= 0) check_val("stream_spacing", 32'(cyc - last_t), 32'd13);
        last_t = cyc;
        got_n++;
      end
    end
    in_valid[0] = 1'b0;
    check_val("stream_count", 32'(got_n), 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
